hazard_sequencer: RTL

//  Pipeline hazard controller for the 5-stage RV32I core (F/D/E/M/W).
//  - Generates operand-forwarding selects for the Execute stage.
//  - Generates stall/flush controls for the F/D, D/E, E/M and M/W pipeline registers:

---
 rtl/hazard_sequencer_if.sv | 53 +++++
 rtl/hazard_sequencer.sv | 125 ++++++++++++
 2 files changed

// File: rtl/hazard_sequencer_if.sv
// Hazard unit handshake bundle between the pipeline datapath and the hazard
// sequencer: register tags and memory status in, forwarding/stall/flush out.
interface hazard_sequencer_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       Rs1D;
  logic [4:0]       Rs2D;
  logic [4:0]       Rs1E;
  logic [4:0]       Rs2E;
  logic [4:0]       RdE;
  logic             ResultSrcE;
  logic             PCSrcE;
  logic [4:0]       RdM;
  logic             RegWriteM;
  logic [4:0]       RdW;
  logic             RegWriteW;
  logic             dmem_req_M;
  logic             dmem_ready;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             StallM;
  logic             FlushD;
  logic             FlushE;
  logic             FlushW;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE,
    output ResultSrcE, PCSrcE,
    output RdM, RegWriteM, RdW, RegWriteW,
    output dmem_req_M, dmem_ready,
    input  ForwardAE, ForwardBE,
    input  StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, FlushW,
    input  mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE,
    input  ResultSrcE, PCSrcE,
    input  RdM, RegWriteM, RdW, RegWriteW,
    input  dmem_req_M, dmem_ready,
    output ForwardAE, ForwardBE,
    output StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushW,
    output mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_sequencer.sv
// Hazard controller for the 5-stage RV32I pipeline: forwarding selects,
// load-use / branch / memory-wait stall+flush, watchdog and perf counters.
module hazard_sequencer #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  hazard_sequencer_if.slave hz
);

  typedef enum logic {
    RUN,
    MEM_WAIT
  } state_t;

  localparam logic [15:0] TO = 16'(TIMEOUT);

  state_t           state;
  logic [15:0]      wait_cnt;
  logic [15:0]      wait_nxt;
  logic             timeout_q;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  logic       lw_stall;
  logic       mem_wait;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       stall_fd;
  logic       stall_em;
  logic       flush_d;
  logic       flush_e;
  logic       flush_w;

  // Execute operand bypass; Memory result wins over Writeback, x0 never
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (rst) begin
      if (hz.RegWriteM && hz.RdM != 5'd0 && hz.RdM == hz.Rs1E)
        fwd_a = 2'b10;
      else if (hz.RegWriteW && hz.RdW != 5'd0 && hz.RdW == hz.Rs1E)
        fwd_a = 2'b01;
      if (hz.RegWriteM && hz.RdM != 5'd0 && hz.RdM == hz.Rs2E)
        fwd_b = 2'b10;
      else if (hz.RegWriteW && hz.RdW != 5'd0 && hz.RdW == hz.Rs2E)
        fwd_b = 2'b01;
    end
  end

  assign lw_stall = hz.ResultSrcE && hz.RdE != 5'd0 &&
                    (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
  assign mem_wait = hz.dmem_req_M && !hz.dmem_ready;

  // Prioritised pipeline controls; memory freeze holds a pending branch in E
  always_comb begin
    stall_fd = 1'b0;
    stall_em = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    flush_w  = 1'b0;
    if (!rst) begin
      stall_fd = 1'b0;
    end else if (mem_wait) begin
      stall_fd = 1'b1;
      stall_em = 1'b1;
      flush_w  = 1'b1;
    end else if (hz.PCSrcE) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (lw_stall) begin
      stall_fd = 1'b1;
      flush_e  = 1'b1;
    end
  end

  // Wait length counts consecutive waiting cycles, starting from RUN
  assign wait_nxt = (state == MEM_WAIT ? wait_cnt : 16'd0) + 16'd1;

  // Memory-wait FSM with watchdog; counter parks at TO once it trips
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      wait_cnt  <= 16'd0;
      timeout_q <= 1'b0;
    end else if (mem_wait) begin
      state <= MEM_WAIT;
      if (wait_cnt != TO || state == RUN)
        wait_cnt <= wait_nxt;
      if (wait_nxt == TO)
        timeout_q <= 1'b1;
    end else begin
      state    <= RUN;
      wait_cnt <= 16'd0;
    end
  end

  // Saturating stall/flush performance counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_fd && stall_q != '1)
        stall_q <= stall_q + 1'b1;
      if (flush_d && flush_q != '1)
        flush_q <= flush_q + 1'b1;
    end
  end

  assign hz.ForwardAE   = fwd_a;
  assign hz.ForwardBE   = fwd_b;
  assign hz.StallF      = stall_fd;
  assign hz.StallD      = stall_fd;
  assign hz.StallE      = stall_em;
  assign hz.StallM      = stall_em;
  assign hz.FlushD      = flush_d;
  assign hz.FlushE      = flush_e;
  assign hz.FlushW      = flush_w;
  assign hz.mem_timeout = timeout_q;
  assign hz.stall_cnt   = stall_q;
  assign hz.flush_cnt   = flush_q;

endmodule
